// File: rtl/particle_pkg.sv
// Shared particle types and constants for the rope simulation pipeline.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Holds the Q16.16 position type, the integrator/streamer state encoding and
// default physical constants. The constraint stage reuses the same constants.
package particle_pkg;

   // Signed Q16.16 fixed-point position.
   typedef logic signed [31:0] fix_t;
   localparam int FRAC_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_INTEGRATE = 2'd1,
      ST_STREAM    = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // g * dt^2 = -0.01 in Q16.16, added to y each integration pass.
   localparam fix_t GRAVITY_DT2_DEFAULT = 32'shFFFF_FD71;
   // Floor height used when the floor clamp is built in.
   localparam fix_t FLOOR_Y_DEFAULT     = 32'sh0000_0000;

endpackage

// File: rtl/verlet_update.sv
// Per-particle Verlet position update: new = 2*cur - prev (+ g*dt^2 on y).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is written.
//
// Ports: cur_x/cur_y, prev_x/prev_y in; new_x/new_y (next cur) and
// new_prev_x/new_prev_y (next prev) out. All signed Q16.16, wrapping.
// Optional macro FLOOR_CLAMP_EN: clamps y to FLOOR_Y and zeroes vertical
// velocity by forcing the stored prev y to the floor as well.
module verlet_update
   import particle_pkg::*;
#(
   parameter fix_t GRAVITY_DT2 = GRAVITY_DT2_DEFAULT,
   parameter fix_t FLOOR_Y     = FLOOR_Y_DEFAULT
) (
   input  fix_t cur_x,
   input  fix_t cur_y,
   input  fix_t prev_x,
   input  fix_t prev_y,
   output fix_t new_x,
   output fix_t new_y,
   output fix_t new_prev_x,
   output fix_t new_prev_y
);

   fix_t y_raw;

   // All arithmetic stays 32 bits wide, so overflow wraps mod 2^32.
   always_comb begin
      new_x      = (cur_x <<< 1) - prev_x;
      new_prev_x = cur_x;
      y_raw      = (cur_y <<< 1) - prev_y + GRAVITY_DT2;
      new_y      = y_raw;
      new_prev_y = cur_y;
`ifdef FLOOR_CLAMP_EN
      // Prev is pinned to the floor too, so the particle rests with no
      // residual downward velocity on the next pass.
      if (y_raw < FLOOR_Y) begin
         new_y      = FLOOR_Y;
         new_prev_y = FLOOR_Y;
      end
`endif
   end

`ifndef FLOOR_CLAMP_EN
   logic unused_floor;
   assign unused_floor = ^FLOOR_Y;
`endif

endmodule

// File: rtl/verlet_stream_stage.sv
// Chain integrator and neighbour-triple streamer feeding the rope constraint stage.
// Latency: N cycles integrate, then one triple per cycle; done at start+2N+1.
// Backpressure: tri_ready low holds the registered triple; write-backs still land.
//
// Ports: clk/rst (sync active-high); start/busy/done step control;
// ld_valid/ld_idx/ld_x/ld_y particle load (IDLE only, sets cur and prev);
// tri_valid/tri_ready/tri_idx/up_*/x/y/down_* triple stream;
// wb_valid/wb_idx/wb_x/wb_y constrained write-back (STREAM only, cur only).
// Optional macro FLOOR_CLAMP_EN enables the floor clamp inside verlet_update.
module verlet_stream_stage
   import particle_pkg::*;
#(
   parameter int   N_PARTICLES = 16,
   parameter fix_t GRAVITY_DT2 = GRAVITY_DT2_DEFAULT,
   parameter fix_t FLOOR_Y     = FLOOR_Y_DEFAULT,
   localparam int  IW          = $clog2(N_PARTICLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          ld_valid,
   input  logic [IW-1:0] ld_idx,
   input  logic [31:0]   ld_x,
   input  logic [31:0]   ld_y,
   output logic          tri_valid,
   input  logic          tri_ready,
   output logic [IW-1:0] tri_idx,
   output logic [31:0]   up_x,
   output logic [31:0]   up_y,
   output logic [31:0]   x,
   output logic [31:0]   y,
   output logic [31:0]   down_x,
   output logic [31:0]   down_y,
   input  logic          wb_valid,
   input  logic [IW-1:0] wb_idx,
   input  logic [31:0]   wb_x,
   input  logic [31:0]   wb_y
);

   localparam logic [IW-1:0] LAST = IW'(N_PARTICLES - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] int_idx_q;

   fix_t cur_x  [N_PARTICLES];
   fix_t cur_y  [N_PARTICLES];
   fix_t prev_x [N_PARTICLES];
   fix_t prev_y [N_PARTICLES];

   fix_t upd_x, upd_y, upd_px, upd_py;

   logic          ld_wr, int_wr, wb_wr, int_last, hs, load_tri;
   logic [IW-1:0] nxt_c, nxt_u, nxt_d;

   assign ld_wr    = (state_q == ST_IDLE) && ld_valid;
   // Particle 0 is pinned during integration; it only moves via write-back.
   assign int_wr   = (state_q == ST_INTEGRATE) && (int_idx_q != '0);
   assign wb_wr    = (state_q == ST_STREAM) && wb_valid;
   assign int_last = (state_q == ST_INTEGRATE) && (int_idx_q == LAST);
   assign hs       = tri_valid && tri_ready;
   assign load_tri = int_last || (hs && (tri_idx != LAST));

   verlet_update #(
      .GRAVITY_DT2 (GRAVITY_DT2),
      .FLOOR_Y     (FLOOR_Y)
   ) u_update (
      .cur_x      (cur_x[int_idx_q]),
      .cur_y      (cur_y[int_idx_q]),
      .prev_x     (prev_x[int_idx_q]),
      .prev_y     (prev_y[int_idx_q]),
      .new_x      (upd_x),
      .new_y      (upd_y),
      .new_prev_x (upd_px),
      .new_prev_y (upd_py)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_d = ST_INTEGRATE;
         end
         ST_INTEGRATE: if (int_idx_q == LAST) state_d = ST_STREAM;
         ST_STREAM:    if (hs && (tri_idx == LAST)) state_d = ST_DONE;
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         int_idx_q <= '0;
      else if ((state_q == ST_INTEGRATE) && !int_last)
         int_idx_q <= int_idx_q + 1'b1;
      else
         int_idx_q <= '0;
   end

   // ---------------- Position memories ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_PARTICLES; k++) begin
            cur_x[k]  <= '0;
            cur_y[k]  <= '0;
            prev_x[k] <= '0;
            prev_y[k] <= '0;
         end
      end else if (ld_wr) begin
         cur_x[ld_idx]  <= ld_x;
         cur_y[ld_idx]  <= ld_y;
         prev_x[ld_idx] <= ld_x;
         prev_y[ld_idx] <= ld_y;
      end else if (int_wr) begin
         cur_x[int_idx_q]  <= upd_x;
         cur_y[int_idx_q]  <= upd_y;
         prev_x[int_idx_q] <= upd_px;
         prev_y[int_idx_q] <= upd_py;
      end else if (wb_wr) begin
         cur_x[wb_idx] <= wb_x;
         cur_y[wb_idx] <= wb_y;
      end
   end

   // Read of cur with the value landing at this same edge bypassed in, so a
   // freshly loaded triple never carries stale data. The integrate bypass
   // only matters for tiny chains where the last integrated particle is a
   // neighbour of particle 0.
   function automatic fix_t fwd_x(input logic [IW-1:0] k);
      fix_t v;
      v = cur_x[k];
      if (int_wr && (int_idx_q == k)) v = upd_x;
      if (wb_wr && (wb_idx == k))     v = wb_x;
      return v;
   endfunction

   function automatic fix_t fwd_y(input logic [IW-1:0] k);
      fix_t v;
      v = cur_y[k];
      if (int_wr && (int_idx_q == k)) v = upd_y;
      if (wb_wr && (wb_idx == k))     v = wb_y;
      return v;
   endfunction

   // ---------------- Triple register ----------------
   always_comb begin
      nxt_c = '0;
      if ((state_q == ST_STREAM) && (tri_idx != LAST)) nxt_c = tri_idx + 1'b1;
      // Chain ends reuse the centre particle as the missing neighbour.
      nxt_u = (nxt_c == '0)   ? nxt_c : nxt_c - 1'b1;
      nxt_d = (nxt_c == LAST) ? nxt_c : nxt_c + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tri_valid <= 1'b0;
         tri_idx   <= '0;
         up_x      <= '0;
         up_y      <= '0;
         x         <= '0;
         y         <= '0;
         down_x    <= '0;
         down_y    <= '0;
      end else begin
         if (load_tri) begin
            tri_idx <= nxt_c;
            up_x    <= fwd_x(nxt_u);
            up_y    <= fwd_y(nxt_u);
            x       <= fwd_x(nxt_c);
            y       <= fwd_y(nxt_c);
            down_x  <= fwd_x(nxt_d);
            down_y  <= fwd_y(nxt_d);
         end
         if (int_last)
            tri_valid <= 1'b1;
         else if (hs && (tri_idx == LAST))
            tri_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_verlet_stream_stage.sv
// Directed bench for verlet_stream_stage with N=4: integration results,
// chain-end triples, stall hold, write-back forwarding and mid-step reset.
// Timing is measured in cycles relative to the edge that samples start.
module tb_verlet_stream_stage;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam logic [31:0] ONE = 32'h0001_0000;
   localparam logic [31:0] WBY = 32'h0000_8000;

`ifdef FLOOR_CLAMP_EN
   localparam logic [31:0] Y1G = 32'h0000_0000;
   localparam logic [31:0] Y3G = 32'h0000_0000;
   localparam logic [31:0] Y6G = 32'h0000_0000;
`else
   localparam logic [31:0] Y1G = 32'hFFFF_FD71;
   localparam logic [31:0] Y3G = 32'hFFFF_F853;
   localparam logic [31:0] Y6G = 32'hFFFF_F0A6;
`endif

   logic          clk = 1'b0;
   logic          rst, start, busy, done;
   logic          ld_valid;
   logic [IW-1:0] ld_idx;
   logic [31:0]   ld_x, ld_y;
   logic          tri_valid, tri_ready;
   logic [IW-1:0] tri_idx;
   logic [31:0]   up_x, up_y, x, y, down_x, down_y;
   logic          wb_valid;
   logic [IW-1:0] wb_idx;
   logic [31:0]   wb_x, wb_y;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   logic [31:0] exp_x [N];
   logic [31:0] exp_y [N];

   verlet_stream_stage #(.N_PARTICLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y),
      .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_idx(tri_idx),
      .up_x(up_x), .up_y(up_y), .x(x), .y(y), .down_x(down_x), .down_y(down_y),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_x(wb_x), .wb_y(wb_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_triple(input int i);
      int u, d;
      u = (i == 0) ? i : i - 1;
      d = (i == N - 1) ? i : i + 1;
      chk($sformatf("tri_idx[%0d]", i), 32'(tri_idx), 32'(i));
      chk($sformatf("up_x[%0d]", i), up_x, exp_x[u]);
      chk($sformatf("up_y[%0d]", i), up_y, exp_y[u]);
      chk($sformatf("x[%0d]", i), x, exp_x[i]);
      chk($sformatf("y[%0d]", i), y, exp_y[i]);
      chk($sformatf("down_x[%0d]", i), down_x, exp_x[d]);
      chk($sformatf("down_y[%0d]", i), down_y, exp_y[d]);
   endtask

   task automatic load(input int i, input logic [31:0] lx, input logic [31:0] ly);
      ld_valid = 1'b1;
      ld_idx   = IW'(i);
      ld_x     = lx;
      ld_y     = ly;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   // Must be entered at a negedge. Drives start, then consumes the stream,
   // optionally stalling at one index and writing back particle 1 on its
   // handshake.
   task automatic run_step(input int stall_at, input int stall_len, input bit do_wb);
      int t0, rel, scnt, first_rel, ei;
      bit done_seen;
      start     = 1'b1;
      tri_ready = 1'b1;
      wb_valid  = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      ld_valid  = 1'b0;
      t0        = cyc;
      chk("busy_after_start", 32'(busy), 32'd1);
      done_seen = 1'b0;
      first_rel = 0;
      scnt      = 0;
      ei        = 0;
      for (int k = 0; k < 80 && !done_seen; k++) begin
         rel      = cyc - t0 + 1;
         wb_valid = 1'b0;
         if (tri_valid && first_rel == 0) begin
            first_rel = rel;
            chk("first_valid_cycle", 32'(rel), 32'(N + 1));
         end
         if (done) begin
            done_seen = 1'b1;
            chk("done_cycle", 32'(rel), 32'(2 * N + 1 + stall_len));
            chk("valid_after_last", 32'(tri_valid), 32'd0);
         end else if (tri_valid) begin
            chk_triple(ei);
            if (ei == stall_at && scnt < stall_len) begin
               tri_ready = 1'b0;
               scnt++;
            end else begin
               tri_ready = 1'b1;
               if (do_wb && ei == 1) begin
                  wb_valid = 1'b1;
                  wb_idx   = 2'd1;
                  wb_x     = exp_x[1];
                  wb_y     = WBY;
                  exp_y[1] = WBY;
               end
               ei++;
            end
         end
         @(negedge clk);
      end
      wb_valid  = 1'b0;
      tri_ready = 1'b1;
      chk("done_seen", 32'(done_seen), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int dcnt;
      rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_idx = '0; ld_x = '0; ld_y = '0;
      tri_ready = 1'b0; wb_valid = 1'b0; wb_idx = '0; wb_x = '0; wb_y = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tri_valid", 32'(tri_valid), 32'd0);
      chk("rst_tri_idx", 32'(tri_idx), 32'd0);
      chk("rst_up_x", up_x, 32'd0);
      chk("rst_y", y, 32'd0);
      chk("rst_down_y", down_y, 32'd0);

      // Step 1: ramp in x, y = 0; particle 3 loaded in the same cycle as start.
      load(0, 32'd0, 32'd0);
      load(1, ONE, 32'd0);
      load(2, 2 * ONE, 32'd0);
      ld_valid = 1'b1; ld_idx = 2'd3; ld_x = 3 * ONE; ld_y = 32'd0;
      for (int i = 0; i < N; i++) begin
         exp_x[i] = 32'(i) * ONE;
         exp_y[i] = (i == 0) ? 32'd0 : Y1G;
      end
      run_step(-1, 0, 1'b0);

      // Step 2: no write-back, y accumulates to 3*g*dt^2.
      for (int i = 1; i < N; i++) exp_y[i] = Y3G;
      run_step(-1, 0, 1'b0);

      // Step 3: stall 5 cycles at idx 2, write back idx 1 on its handshake.
      for (int i = 1; i < N; i++) exp_y[i] = Y6G;
      run_step(2, 5, 1'b1);

      // Step 4: abort mid-stream with reset; no done may follow.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40 && !(tri_valid && tri_idx == 2'd2); k++) @(negedge clk);
      chk("abort_at_idx2", 32'(tri_idx), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tri_valid", 32'(tri_valid), 32'd0);
      chk("abort_tri_idx", 32'(tri_idx), 32'd0);
      chk("abort_y", y, 32'd0);
      chk("abort_down_x", down_x, 32'd0);
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);

      // Step 5: restart without reload; memories were cleared by reset.
      for (int i = 0; i < N; i++) begin
         exp_x[i] = 32'd0;
         exp_y[i] = (i == 0) ? 32'd0 : Y1G;
      end
      run_step(-1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
